// File: rtl/snake_engine_pkg.sv
// rtl/snake_engine_pkg.sv - shared constants, encodings and helpers for the snake game engine
//
// Purpose: direction and FSM state encodings, grid geometry, start layout and
//          small pure helpers used by the engine.
// Ports:   none (package).
package snake_engine_pkg;

  typedef logic [1:0] dir_t;

  localparam dir_t DIR_UP    = 2'd0;
  localparam dir_t DIR_DOWN  = 2'd1;
  localparam dir_t DIR_LEFT  = 2'd2;
  localparam dir_t DIR_RIGHT = 2'd3;

  localparam int GRID_W = 40;
  localparam int GRID_H = 30;
  localparam int CELL   = 16;

  localparam logic [9:0] START_X  = 10'd20;
  localparam logic [9:0] START_Y  = 10'd15;
  localparam logic [9:0] APPLE_X0 = 10'd30;
  localparam logic [9:0] APPLE_Y0 = 10'd15;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RUN   = 3'd1;
  localparam logic [2:0] ST_SCAN  = 3'd2;
  localparam logic [2:0] ST_MOVE  = 3'd3;
  localparam logic [2:0] ST_PLACE = 3'd4;
  localparam logic [2:0] ST_OVER  = 3'd5;

  // UP/DOWN and LEFT/RIGHT differ only in bit 0.
  function automatic dir_t dir_opposite(input dir_t d);
    return d ^ 2'b01;
  endfunction

  function automatic logic is_wall(input logic [9:0] x, input logic [9:0] y);
    return (x == 10'd0) || (x == 10'(GRID_W - 1)) ||
           (y == 10'd0) || (y == 10'(GRID_H - 1));
  endfunction

  function automatic logic is_playable(input logic [9:0] x, input logic [9:0] y);
    return (x >= 10'd1) && (x <= 10'(GRID_W - 2)) &&
           (y >= 10'd1) && (y <= 10'(GRID_H - 2));
  endfunction

endpackage

// File: rtl/snake_engine_lfsr16.sv
// rtl/snake_engine_lfsr16.sv - free-running 16-bit Fibonacci LFSR for apple placement
//
// Purpose: maximal-length LFSR, taps 16,14,13,11; shifts every cycle.
// Ports:   clk   - system clock
//          rst_n - asynchronous active-low reset, loads SEED
//          q     - current LFSR state (never zero for a non-zero SEED)
module snake_engine_lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] q
);

  logic feedback;

  assign feedback = q[15] ^ q[13] ^ q[12] ^ q[10];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= SEED;
    end else begin
      q <= {q[14:0], feedback};
    end
  end

endmodule

// File: rtl/snake_engine.sv
// rtl/snake_engine.sv - snake game-state engine feeding the pixel renderer
//
// Purpose: owns snake body, length, apple, score and game_over; advances one
//          grid step per accepted tick with a per-segment self-collision scan
//          and an LFSR-driven apple placement search.
// Ports:   clk, rst_n            - clock, asynchronous active-low reset
//          tick                  - one-cycle move strobe
//          start                 - one-cycle (re)start pulse
//          btn_up/down/left/right- level direction requests
//          snake_x, snake_y      - packed segment coordinates, 10 bits each, head at 0
//          snake_length          - valid segment count
//          apple_x, apple_y      - apple cell
//          game_over, score      - collision flag, saturating apple count
//          busy                  - high while scanning, moving or placing
module snake_engine
  import snake_engine_pkg::*;
#(
  parameter int          SNAKE_MAX = 64,
  parameter int          INIT_LEN  = 3,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      tick,
  input  logic                      start,
  input  logic                      btn_up,
  input  logic                      btn_down,
  input  logic                      btn_left,
  input  logic                      btn_right,
  output logic [10*SNAKE_MAX-1:0]   snake_x,
  output logic [10*SNAKE_MAX-1:0]   snake_y,
  output logic [6:0]                snake_length,
  output logic [9:0]                apple_x,
  output logic [9:0]                apple_y,
  output logic                      game_over,
  output logic [7:0]                score,
  output logic                      busy
);

  localparam int         IW       = $clog2(SNAKE_MAX);
  localparam logic [6:0] LEN_INIT = 7'(INIT_LEN);
  localparam logic [6:0] LEN_MAX  = 7'(SNAKE_MAX);

  logic [9:0]  seg_x [SNAKE_MAX];
  logic [9:0]  seg_y [SNAKE_MAX];
  logic [2:0]  state;
  dir_t        dir;
  dir_t        pend_dir;
  logic [6:0]  length;
  logic [9:0]  nh_x;
  logic [9:0]  nh_y;
  logic        eat;
  logic [6:0]  idx;
  logic [9:0]  cand_x;
  logic [9:0]  cand_y;
  logic        cand_ok;
  logic [15:0] lfsr;

  snake_engine_lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (lfsr)
  );

  // Direction request: highest-priority pressed button.
  logic req_valid;
  dir_t req_dir;

  always_comb begin
    req_valid = 1'b1;
    req_dir   = DIR_RIGHT;
    if (btn_up) begin
      req_dir = DIR_UP;
    end else if (btn_down) begin
      req_dir = DIR_DOWN;
    end else if (btn_left) begin
      req_dir = DIR_LEFT;
    end else if (btn_right) begin
      req_dir = DIR_RIGHT;
    end else begin
      req_valid = 1'b0;
    end
  end

  // Candidate next head, computed from the direction that the tick will commit.
  logic [9:0] next_x;
  logic [9:0] next_y;
  logic       next_eat;

  always_comb begin
    next_x = seg_x[0];
    next_y = seg_y[0];
    case (pend_dir)
      DIR_UP:   next_y = seg_y[0] - 10'd1;
      DIR_DOWN: next_y = seg_y[0] + 10'd1;
      DIR_LEFT: next_x = seg_x[0] - 10'd1;
      default:  next_x = seg_x[0] + 10'd1;
    endcase
  end

  assign next_eat = (next_x == apple_x) && (next_y == apple_y);

  // One shared segment read port serves both the body scan and the apple scan.
  logic [9:0] sel_x;
  logic [9:0] sel_y;
  logic       scan_hit;
  logic       cand_hit;
  logic [6:0] scan_last;

  assign sel_x    = seg_x[idx[IW-1:0]];
  assign sel_y    = seg_y[idx[IW-1:0]];
  assign scan_hit = (sel_x == nh_x) && (sel_y == nh_y);
  assign cand_hit = (sel_x == cand_x) && (sel_y == cand_y);
  // Without eating, the tail cell is vacated in the same move, so it is skipped.
  assign scan_last = eat ? (length - 7'd1) : (length - 7'd2);

  logic [9:0] lfsr_x;
  logic [9:0] lfsr_y;
  logic       lfsr_in_range;
  logic       unused_lfsr;

  assign lfsr_x        = {4'd0, lfsr[5:0]};
  assign lfsr_y        = {5'd0, lfsr[10:6]};
  assign lfsr_in_range = is_playable(lfsr_x, lfsr_y);
  assign unused_lfsr   = ^lfsr[15:11];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      dir       <= DIR_RIGHT;
      pend_dir  <= DIR_RIGHT;
      length    <= LEN_INIT;
      apple_x   <= APPLE_X0;
      apple_y   <= APPLE_Y0;
      game_over <= 1'b0;
      score     <= 8'd0;
      nh_x      <= 10'd0;
      nh_y      <= 10'd0;
      eat       <= 1'b0;
      idx       <= 7'd0;
      cand_x    <= 10'd0;
      cand_y    <= 10'd0;
      cand_ok   <= 1'b0;
    end else begin
      if (req_valid && (req_dir != dir_opposite(dir))) begin
        pend_dir <= req_dir;
      end

      if (start) begin
        state     <= ST_RUN;
        dir       <= DIR_RIGHT;
        pend_dir  <= DIR_RIGHT;
        length    <= LEN_INIT;
        apple_x   <= APPLE_X0;
        apple_y   <= APPLE_Y0;
        game_over <= 1'b0;
        score     <= 8'd0;
        eat       <= 1'b0;
        idx       <= 7'd0;
        cand_ok   <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
          end
          ST_RUN: begin
            if (tick) begin
              dir  <= pend_dir;
              nh_x <= next_x;
              nh_y <= next_y;
              eat  <= next_eat;
              idx  <= 7'd0;
              if (is_wall(next_x, next_y)) begin
                state     <= ST_OVER;
                game_over <= 1'b1;
              end else begin
                state <= ST_SCAN;
              end
            end
          end
          ST_SCAN: begin
            if (scan_hit) begin
              state     <= ST_OVER;
              game_over <= 1'b1;
            end else if (idx == scan_last) begin
              state <= ST_MOVE;
            end else begin
              idx <= idx + 7'd1;
            end
          end
          ST_MOVE: begin
            if (eat) begin
              if (length < LEN_MAX) begin
                length <= length + 7'd1;
              end
              if (score != 8'hFF) begin
                score <= score + 8'd1;
              end
              cand_ok <= 1'b0;
              state   <= ST_PLACE;
            end else begin
              state <= ST_RUN;
            end
          end
          ST_PLACE: begin
            if (!cand_ok) begin
              // Off-grid candidates are simply skipped; the LFSR has moved on next cycle.
              if (lfsr_in_range) begin
                cand_x  <= lfsr_x;
                cand_y  <= lfsr_y;
                cand_ok <= 1'b1;
                idx     <= 7'd0;
              end
            end else if (cand_hit) begin
              cand_ok <= 1'b0;
            end else if (idx == (length - 7'd1)) begin
              apple_x <= cand_x;
              apple_y <= cand_y;
              cand_ok <= 1'b0;
              state   <= ST_RUN;
            end else begin
              idx <= idx + 7'd1;
            end
          end
          ST_OVER: begin
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // Body storage: only reset, restart and the single MOVE cycle touch it,
  // so the renderer always sees a whole snake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SNAKE_MAX; k++) begin
        seg_x[k] <= (k < INIT_LEN) ? (START_X - 10'(k)) : 10'd0;
        seg_y[k] <= (k < INIT_LEN) ? START_Y : 10'd0;
      end
    end else if (start) begin
      for (int k = 0; k < SNAKE_MAX; k++) begin
        seg_x[k] <= (k < INIT_LEN) ? (START_X - 10'(k)) : 10'd0;
        seg_y[k] <= (k < INIT_LEN) ? START_Y : 10'd0;
      end
    end else if (state == ST_MOVE) begin
      for (int k = SNAKE_MAX - 1; k >= 1; k--) begin
        seg_x[k] <= seg_x[k-1];
        seg_y[k] <= seg_y[k-1];
      end
      seg_x[0] <= nh_x;
      seg_y[0] <= nh_y;
    end
  end

  for (genvar k = 0; k < SNAKE_MAX; k++) begin : g_pack
    assign snake_x[k*10 +: 10] = seg_x[k];
    assign snake_y[k*10 +: 10] = seg_y[k];
  end

  assign snake_length = length;
  assign busy         = (state == ST_SCAN) || (state == ST_MOVE) || (state == ST_PLACE);

endmodule

// File: tb/tb_snake_engine.sv
// tb/tb_snake_engine.sv - scoreboard testbench for snake_engine
module tb_snake_engine;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         tick;
  logic         start;
  logic         btn_up;
  logic         btn_down;
  logic         btn_left;
  logic         btn_right;
  logic [639:0] snake_x;
  logic [639:0] snake_y;
  logic [6:0]   snake_length;
  logic [9:0]   apple_x;
  logic [9:0]   apple_y;
  logic         game_over;
  logic [7:0]   score;
  logic         busy;

  always #5 clk = ~clk;

  snake_engine dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick         (tick),
    .start        (start),
    .btn_up       (btn_up),
    .btn_down     (btn_down),
    .btn_left     (btn_left),
    .btn_right    (btn_right),
    .snake_x      (snake_x),
    .snake_y      (snake_y),
    .snake_length (snake_length),
    .apple_x      (apple_x),
    .apple_y      (apple_y),
    .game_over    (game_over),
    .score        (score),
    .busy         (busy)
  );

  typedef struct packed {
    logic [639:0] sx;
    logic [639:0] sy;
    logic [6:0]   len;
    logic [7:0]   score;
    logic         go;
    logic         eat;
    logic [9:0]   ax;
    logic [9:0]   ay;
  } exp_t;

  exp_t q[$];
  int   tests  = 0;
  int   fails  = 0;
  int   pushed = 0;
  int   seen   = 0;
  bit   mon_en = 0;

  // Reference model: segment list (head first), game variables.
  int mx[64];
  int my[64];
  int mlen, mdir, mpend, mscore, max_, may;
  bit mover, mactive;

  function automatic void check(string name, longint act, longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic void model_init();
    for (int k = 0; k < 64; k++) begin
      mx[k] = (k < 3) ? 20 - k : 0;
      my[k] = (k < 3) ? 15 : 0;
    end
    mlen = 3; mdir = 3; mpend = 3; mscore = 0;
    max_ = 30; may = 15; mover = 0;
  endfunction

  function automatic exp_t snap(bit eat);
    exp_t e;
    e = '0;
    for (int k = 0; k < 64; k++) begin
      e.sx[k*10 +: 10] = 10'(mx[k]);
      e.sy[k*10 +: 10] = 10'(my[k]);
    end
    e.len = 7'(mlen); e.score = 8'(mscore); e.go = mover; e.eat = eat;
    e.ax = 10'(max_); e.ay = 10'(may);
    return e;
  endfunction

  function automatic void compare_dut(string tag, exp_t e);
    int bi;
    bit on;
    check({tag, ".len"}, snake_length, e.len);
    check({tag, ".score"}, score, e.score);
    check({tag, ".game_over"}, game_over, e.go);
    bi = 0;
    for (int i = 0; i < int'(e.len); i++) begin
      if (snake_x[i*10 +: 10] != e.sx[i*10 +: 10] || snake_y[i*10 +: 10] != e.sy[i*10 +: 10]) begin
        bi = i;
        break;
      end
    end
    check($sformatf("%s.seg%0d(x*1000+y)", tag, bi),
          snake_x[bi*10 +: 10] * 1000 + snake_y[bi*10 +: 10],
          e.sx[bi*10 +: 10] * 1000 + e.sy[bi*10 +: 10]);
    if (!e.eat) begin
      check({tag, ".apple_x"}, apple_x, e.ax);
      check({tag, ".apple_y"}, apple_y, e.ay);
    end else begin
      check({tag, ".apple_in_grid"},
            (apple_x >= 1 && apple_x <= 38 && apple_y >= 1 && apple_y <= 28), 1);
      on = 0;
      for (int i = 0; i < int'(e.len); i++)
        if (apple_x == e.sx[i*10 +: 10] && apple_y == e.sy[i*10 +: 10]) on = 1;
      check({tag, ".apple_on_snake"}, on, 0);
    end
  endfunction

  function automatic int dxf(int d);
    return (d == 2) ? -1 : (d == 3) ? 1 : 0;
  endfunction
  function automatic int dyf(int d);
    return (d == 0) ? -1 : (d == 1) ? 1 : 0;
  endfunction
  function automatic int ccw(int d);
    return (d == 3) ? 0 : (d == 0) ? 2 : (d == 2) ? 1 : 3;
  endfunction
  function automatic int cw(int d);
    return (d == 0) ? 3 : (d == 3) ? 1 : (d == 1) ? 2 : 0;
  endfunction
  function automatic bit playable(int x, int y);
    return x >= 1 && x <= 38 && y >= 1 && y <= 28;
  endfunction

  function automatic void model_btn(int b);
    if (b >= 0 && b != (mdir ^ 1)) mpend = b;
  endfunction

  // One accepted move, computed from the game rules; pushes the expected outcome.
  function automatic void model_tick();
    int nx, ny, lim;
    bit eat, hit;
    if (!mactive || mover) return;
    mdir = mpend;
    nx = mx[0] + dxf(mdir);
    ny = my[0] + dyf(mdir);
    eat = (nx == max_) && (ny == may);
    if (!playable(nx, ny)) begin
      mover = 1;
    end else begin
      lim = eat ? mlen : mlen - 1;
      hit = 0;
      for (int i = 0; i < lim; i++) if (mx[i] == nx && my[i] == ny) hit = 1;
      if (hit) begin
        mover = 1;
      end else begin
        for (int k = 63; k >= 1; k--) begin
          mx[k] = mx[k-1];
          my[k] = my[k-1];
        end
        mx[0] = nx; my[0] = ny;
        if (eat) begin
          if (mlen < 64) mlen++;
          if (mscore < 255) mscore++;
        end
      end
    end
    q.push_back(snap(eat && !mover));
    pushed++;
  endfunction

  // Monitor: a step is complete when busy falls or game_over rises.
  initial begin
    bit   pb, pg;
    exp_t e;
    pb = 0; pg = 0;
    forever begin
      @(negedge clk);
      if (mon_en && ((pb && !busy) || (!pg && game_over))) begin
        if (q.size() == 0) begin
          check("unexpected_step", 1, 0);
        end else begin
          e = q.pop_front();
          compare_dut($sformatf("step%0d", seen), e);
          if (e.eat) begin
            max_ = apple_x;
            may  = apple_y;
          end
        end
        seen++;
      end
      pb = busy;
      pg = game_over;
    end
  end

  task automatic set_btn(int b);
    btn_up = (b == 0); btn_down = (b == 1); btn_left = (b == 2); btn_right = (b == 3);
  endtask

  task automatic wait_done(output int lat);
    int n;
    n = 0; lat = -1;
    while (n < 4000 && (busy || seen != pushed)) begin
      if (!busy && lat < 0) lat = n;
      @(negedge clk);
      n++;
    end
    if (lat < 0) lat = n;
    if (n >= 4000) begin
      check("wait_done_timeout", n, 0);
      q.delete();
      seen = pushed;
    end
  endtask

  task automatic step(int b, output int lat);
    @(negedge clk);
    set_btn(b);
    model_btn(b);
    @(negedge clk);
    set_btn(-1);
    tick = 1;
    model_tick();
    @(negedge clk);
    tick = 0;
    wait_done(lat);
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1;
    model_init();
    mactive = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic square();
    int c1, c2, c3, lat;
    c1 = ccw(mdir); c2 = ccw(c1); c3 = ccw(c2);
    if (!playable(mx[0] + dxf(c1), my[0] + dyf(c1)) ||
        !playable(mx[0] + dxf(c1) + dxf(c2), my[0] + dyf(c1) + dyf(c2))) begin
      c1 = cw(mdir); c2 = cw(c1); c3 = cw(c2);
    end
    step(c1, lat); step(c2, lat); step(c3, lat);
  endtask

  task automatic to_apple(int target);
    int dx, dy, want, lat, n;
    n = 0;
    while (n < 300 && mscore < target && !mover) begin
      dx = max_ - mx[0]; dy = may - my[0];
      if (dx > 0 && mdir != 2) want = 3;
      else if (dx < 0 && mdir != 3) want = 2;
      else if (dy > 0 && mdir != 0) want = 1;
      else if (dy < 0 && mdir != 1) want = 0;
      else if (mdir >= 2) want = (my[0] > 14) ? 0 : 1;
      else want = (mx[0] > 19) ? 2 : 3;
      step(want, lat);
      n++;
    end
  endtask

  initial begin
    int  lat, b, bad;
    bit  found;
    rst_n = 0; tick = 0; start = 0; set_btn(-1);
    model_init();
    mactive = 0;
    repeat (3) @(negedge clk);
    compare_dut("reset", snap(0));
    check("reset.busy", busy, 0);
    bad = 0;
    for (int k = 3; k < 64; k++) if (snake_x[k*10 +: 10] != 0 || snake_y[k*10 +: 10] != 0) bad++;
    check("reset.unused_segs_nonzero", bad, 0);
    rst_n = 1;
    step(-1, lat);
    compare_dut("idle_tick", snap(0));
    mon_en = 1;

    do_start();
    step(-1, lat);
    check("first_step_latency_le5", lat <= 5, 1);
    check("first_step.head_x", snake_x[9:0], 21);
    step(2, lat);
    check("reverse_rejected.head_x", snake_x[9:0], 22);
    step(0, lat);
    check("turn_up.head_y", snake_y[9:0], 14);

    do_start();
    repeat (10) step(3, lat);
    check("eat.len", snake_length, 4);
    check("eat.score", score, 1);
    square();
    check("tail_chase.game_over", game_over, mover);
    to_apple(2);
    if (mscore == 2 && !mover && mlen == 5) begin
      square();
      check("self_hit.game_over", game_over, 1);
    end

    do_start();
    repeat (19) step(3, lat);
    check("wall.game_over", game_over, 1);
    check("wall.head_x", snake_x[9:0], 38);
    repeat (3) step(3, lat);
    compare_dut("over_frozen", snap(0));
    do_start();
    compare_dut("restart", snap(0));

    @(negedge clk);
    tick = 1;
    model_tick();
    @(negedge clk);
    tick = 0;
    check("scan.busy", busy, 1);
    tick = 1;
    @(negedge clk);
    tick = 0;
    wait_done(lat);
    repeat (5) @(negedge clk);
    compare_dut("tick_in_scan", snap(0));

    for (int r = 0; r < 200; r++) begin
      if (mover) do_start();
      b = $urandom_range(0, 4);
      step((b == 4) ? -1 : b, lat);
    end

    do_start();
    repeat (9) step(3, lat);
    @(negedge clk);
    tick = 1;
    model_tick();
    @(negedge clk);
    tick = 0;
    found = 0;
    for (int n = 0; n < 100 && !found; n++) begin
      if (busy && score == 1) found = 1;
      else @(negedge clk);
    end
    check("place_reached", found, 1);
    mon_en = 0;
    rst_n = 0;
    #1;
    model_init();
    mactive = 0;
    q.delete();
    seen = pushed;
    compare_dut("rst_in_place", snap(0));
    check("rst_in_place.busy", busy, 0);
    @(negedge clk);
    compare_dut("rst_in_place_held", snap(0));
    rst_n = 1;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
